// File: rtl/sv32_ptw_tlb_if.sv
// Core-side translation handshake and memory-side PTE read port for the
// Sv32 translation unit.
interface sv32_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_acc;
  logic        resp_valid;
  logic [33:0] resp_paddr;
  logic        resp_fault;

  modport master (output req_valid, req_vaddr, req_acc,
                  input  req_ready, resp_valid, resp_paddr, resp_fault);
  modport slave  (input  req_valid, req_vaddr, req_acc,
                  output req_ready, resp_valid, resp_paddr, resp_fault);
endinterface

interface sv32_mem_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [33:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (output mem_req_valid, mem_req_addr,
                  input  mem_req_ready, mem_resp_valid, mem_resp_data);
  modport slave  (input  mem_req_valid, mem_req_addr,
                  output mem_req_ready, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/sv32_ptw_tlb.sv
// Sv32 translation unit: fully-associative TLB with round-robin refill and a
// two-level page-table walker that reports page faults to the core.
module sv32_ptw_tlb #(
  parameter int TLB_ENTRIES = 4,
  parameter bit CHECK_AD    = 1'b1,
  parameter int PA_WIDTH    = 34
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         satp_mode,
  input  logic [21:0]  satp_ppn,
  input  logic         flush,
  sv32_req_if.slave    core,
  sv32_mem_if.master   mem
);

  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} state_t;

  state_t                         state_q, state_d;
  logic [31:0]                    vaddr_q, vaddr_d;
  logic [1:0]                     acc_q, acc_d;
  logic [PA_WIDTH-1:0]            paddr_q, paddr_d;
  logic [PA_WIDTH-1:0]            mem_addr_q, mem_addr_d;
  logic                           fault_q, fault_d;
  logic                           flush_seen_q, flush_seen_d;
  logic [IDX_W-1:0]               rr_q, rr_d;
  logic [TLB_ENTRIES-1:0]         tlb_valid_q, tlb_valid_d;
  logic [TLB_ENTRIES-1:0]         tlb_mega_q, tlb_mega_d;
  logic [TLB_ENTRIES-1:0][19:0]   tlb_vpn_q, tlb_vpn_d;
  logic [TLB_ENTRIES-1:0][21:0]   tlb_ppn_q, tlb_ppn_d;
  logic [TLB_ENTRIES-1:0][4:0]    tlb_flags_q, tlb_flags_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [21:0]      pte_ppn;
  logic [4:0]       pte_flags;
  logic             pte_bad, pte_leaf, pte_fail;
  logic             fill_en, fill_mega;

  // Flags are packed {D, A, X, W, R}; access 11 behaves like a load.
  function automatic logic leaf_fail(input logic [4:0] f, input logic [1:0] acc);
    logic perm_ok;
    case (acc)
      2'b01:   perm_ok = f[1];
      2'b10:   perm_ok = f[2];
      default: perm_ok = f[0];
    endcase
    leaf_fail = !perm_ok || (CHECK_AD && (!f[3] || (acc == 2'b01 && !f[4])));
  endfunction

  assign pte_ppn   = mem.mem_resp_data[31:10];
  assign pte_flags = {mem.mem_resp_data[7], mem.mem_resp_data[6], mem.mem_resp_data[3],
                      mem.mem_resp_data[2], mem.mem_resp_data[1]};
  assign pte_bad   = !mem.mem_resp_data[0] || (!mem.mem_resp_data[1] && mem.mem_resp_data[2]);
  assign pte_leaf  = mem.mem_resp_data[1] || mem.mem_resp_data[3];
  assign pte_fail  = leaf_fail(pte_flags, acc_q);

  // Lowest matching slot wins; megapage entries ignore vpn0.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_valid_q[i] && tlb_vpn_q[i][19:10] == core.req_vaddr[31:22] &&
          (tlb_mega_q[i] || tlb_vpn_q[i][9:0] == core.req_vaddr[21:12])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    acc_d        = acc_q;
    paddr_d      = paddr_q;
    fault_d      = fault_q;
    mem_addr_d   = mem_addr_q;
    flush_seen_d = flush_seen_q | (flush && state_q != IDLE);
    fill_en      = 1'b0;
    fill_mega    = 1'b0;
    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          vaddr_d      = core.req_vaddr;
          acc_d        = core.req_acc;
          flush_seen_d = 1'b0;
          fault_d      = 1'b0;
          state_d      = RESP;
          if (!satp_mode) begin
            paddr_d = {2'b00, core.req_vaddr};
          end else if (hit) begin
            fault_d = leaf_fail(tlb_flags_q[hit_idx], core.req_acc);
            paddr_d = tlb_mega_q[hit_idx] ?
                      {tlb_ppn_q[hit_idx][21:10], core.req_vaddr[21:0]} :
                      {tlb_ppn_q[hit_idx], core.req_vaddr[11:0]};
          end else begin
            mem_addr_d = {satp_ppn, core.req_vaddr[31:22], 2'b00};
            state_d    = L1_REQ;
          end
        end
      end
      L1_REQ: if (mem.mem_req_ready) state_d = L1_WAIT;
      L1_WAIT: begin
        if (mem.mem_resp_valid) begin
          state_d = RESP;
          fault_d = 1'b1;
          if (!pte_bad && pte_leaf) begin
            if (pte_ppn[9:0] == 10'd0) begin
              fault_d   = pte_fail;
              paddr_d   = {pte_ppn[21:10], vaddr_q[21:0]};
              fill_en   = !pte_fail;
              fill_mega = 1'b1;
            end
          end else if (!pte_bad) begin
            mem_addr_d = {pte_ppn, vaddr_q[21:12], 2'b00};
            fault_d    = fault_q;
            state_d    = L0_REQ;
          end
        end
      end
      L0_REQ: if (mem.mem_req_ready) state_d = L0_WAIT;
      L0_WAIT: begin
        if (mem.mem_resp_valid) begin
          state_d = RESP;
          fault_d = 1'b1;
          if (!pte_bad && pte_leaf) begin
            fault_d = pte_fail;
            paddr_d = {pte_ppn, vaddr_q[11:0]};
            fill_en = !pte_fail;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush seen at any point of the walk suppresses its refill.
  always_comb begin
    tlb_valid_d = tlb_valid_q;
    tlb_mega_d  = tlb_mega_q;
    tlb_vpn_d   = tlb_vpn_q;
    tlb_ppn_d   = tlb_ppn_q;
    tlb_flags_d = tlb_flags_q;
    rr_d        = rr_q;
    if (fill_en && !flush && !flush_seen_q) begin
      tlb_valid_d[rr_q] = 1'b1;
      tlb_mega_d[rr_q]  = fill_mega;
      tlb_vpn_d[rr_q]   = vaddr_q[31:12];
      tlb_ppn_d[rr_q]   = pte_ppn;
      tlb_flags_d[rr_q] = pte_flags;
      rr_d = (rr_q == IDX_W'(TLB_ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);
    end
    if (flush) tlb_valid_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      vaddr_q      <= '0;
      acc_q        <= '0;
      paddr_q      <= '0;
      mem_addr_q   <= '0;
      fault_q      <= 1'b0;
      flush_seen_q <= 1'b0;
      rr_q         <= '0;
      tlb_valid_q  <= '0;
      tlb_mega_q   <= '0;
      tlb_vpn_q    <= '0;
      tlb_ppn_q    <= '0;
      tlb_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      acc_q        <= acc_d;
      paddr_q      <= paddr_d;
      mem_addr_q   <= mem_addr_d;
      fault_q      <= fault_d;
      flush_seen_q <= flush_seen_d;
      rr_q         <= rr_d;
      tlb_valid_q  <= tlb_valid_d;
      tlb_mega_q   <= tlb_mega_d;
      tlb_vpn_q    <= tlb_vpn_d;
      tlb_ppn_q    <= tlb_ppn_d;
      tlb_flags_q  <= tlb_flags_d;
    end
  end

  assign core.req_ready    = (state_q == IDLE);
  assign core.resp_valid   = (state_q == RESP);
  assign core.resp_paddr   = paddr_q;
  assign core.resp_fault   = fault_q;
  assign mem.mem_req_valid = (state_q == L1_REQ) || (state_q == L0_REQ);
  assign mem.mem_req_addr  = mem_addr_q;

endmodule
